ra_march_sdr: RTL and testbench

Self-contained march-test sequencer that sits directly upstream of the 64x72 SDR test array and drives its two read ports and one write port. It runs a fixed four-element march (W0 up, R0W1 up, R1W0 down, R0 down) with a host-supplied 72-bit background. It compares both read ports against the expected data and reports pass/fail, the first failing address/port, and an error count. It replaces host-driven port traffic during bring-up and characterisation of the array shard.

---
 rtl/ra_march_sdr.sv | 170 +++++++++++++++++
 tb/tb_ra_march_sdr.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ra_march_sdr.sv
// Four-element march sequencer (W0 up, R0W1 up, R1W0 down, R0 down) driving a 64x72 SDR array.
// Define RA_MARCH_CHKBD_EN to invert the background on odd addresses (checkerboard).
module ra_march_sdr #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [0:71] bkgnd,
    output logic        rd_enb_0,
    output logic        rd_enb_1,
    output logic [0:5]  rd_adr_0,
    output logic [0:5]  rd_adr_1,
    input  logic [0:71] rd_dat_0,
    input  logic [0:71] rd_dat_1,
    output logic        wr_enb_0,
    output logic [0:5]  wr_adr_0,
    output logic [0:71] wr_dat_0,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [0:5]  fail_adr,
    output logic        fail_port,
    output logic [7:0]  err_cnt
);

    typedef enum logic [3:0] {
        IDLE, W0, R0W1_R, R0W1_W, R1W0_R, R1W0_W, R0, DRAIN, DONE
    } state_t;

    typedef struct packed {
        logic        vld;
        logic [0:5]  adr;
        logic [0:71] exp;
    } stage_t;

    localparam logic [1:0] DRAIN_LAST = 2'(RD_LAT - 1);

    state_t      state, nxt_state;
    logic [0:5]  adr, nxt_adr;
    logic [1:0]  drain_cnt;
    logic [0:71] d_reg, src, nxt_pat;
    logic [0:71] rd_exp;
    logic        start_acc, nxt_wr, nxt_rd, chk;
    stage_t      pipe [RD_LAT];
    stage_t      cmp;
    logic        mis0, mis1;
    logic [8:0]  err_sum;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        nxt_state = state;
        nxt_adr   = adr;
        start_acc = 1'b0;
        unique case (state)
            IDLE, DONE: if (start) begin
                start_acc = 1'b1;
                nxt_state = W0;
                nxt_adr   = 6'd0;
            end
            W0: if (adr == 6'd63) begin
                nxt_state = R0W1_R;
                nxt_adr   = 6'd0;
            end else begin
                nxt_adr = adr + 6'd1;
            end
            R0W1_R: nxt_state = R0W1_W;
            R0W1_W: if (adr == 6'd63) begin
                nxt_state = R1W0_R;
            end else begin
                nxt_state = R0W1_R;
                nxt_adr   = adr + 6'd1;
            end
            R1W0_R: nxt_state = R1W0_W;
            R1W0_W: if (adr == 6'd0) begin
                nxt_state = R0;
                nxt_adr   = 6'd63;
            end else begin
                nxt_state = R1W0_R;
                nxt_adr   = adr - 6'd1;
            end
            R0: if (adr == 6'd0) begin
                nxt_state = DRAIN;
            end else begin
                nxt_adr = adr - 6'd1;
            end
            DRAIN: if (drain_cnt == DRAIN_LAST) nxt_state = DONE;
            default: nxt_state = IDLE;
        endcase

        chk = 1'b0;
`ifdef RA_MARCH_CHKBD_EN
        chk = nxt_adr[5];
`endif
        // The background is not yet in d_reg on the cycle the start is accepted.
        src     = start_acc ? bkgnd : d_reg;
        nxt_pat = src ^ {72{((nxt_state == R0W1_W) || (nxt_state == R1W0_R)) ^ chk}};
        nxt_wr  = (nxt_state == W0) || (nxt_state == R0W1_W) || (nxt_state == R1W0_W);
        nxt_rd  = (nxt_state == R0W1_R) || (nxt_state == R1W0_R) || (nxt_state == R0);
    end

    // Outputs are registered from the next state, so they show the action of the current state.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            adr       <= '0;
            drain_cnt <= '0;
            d_reg     <= '0;
            rd_exp    <= '0;
            rd_enb_0  <= 1'b0;
            rd_enb_1  <= 1'b0;
            rd_adr_0  <= '0;
            rd_adr_1  <= '0;
            wr_enb_0  <= 1'b0;
            wr_adr_0  <= '0;
            wr_dat_0  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= nxt_state;
            adr       <= nxt_adr;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            if (start_acc) d_reg <= bkgnd;
            wr_enb_0  <= nxt_wr;
            wr_adr_0  <= nxt_wr ? nxt_adr : 6'd0;
            wr_dat_0  <= nxt_wr ? nxt_pat : '0;
            rd_enb_0  <= nxt_rd;
            rd_enb_1  <= nxt_rd;
            rd_adr_0  <= nxt_rd ? nxt_adr : 6'd0;
            rd_adr_1  <= nxt_rd ? nxt_adr : 6'd0;
            rd_exp    <= nxt_rd ? nxt_pat : '0;
            busy      <= !((nxt_state == IDLE) || (nxt_state == DONE));
            done      <= (nxt_state == DONE);
        end
    end

    assign cmp     = pipe[RD_LAT-1];
    assign mis0    = cmp.vld && (rd_dat_0 != cmp.exp);
    assign mis1    = cmp.vld && (rd_dat_1 != cmp.exp);
    assign err_sum = {1'b0, err_cnt} + 9'(mis0) + 9'(mis1);

    // NOTE: the compare pipe is reset so an aborted run cannot leave valid stages behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
            fail      <= 1'b0;
            fail_adr  <= '0;
            fail_port <= 1'b0;
            err_cnt   <= '0;
        end else begin
            pipe[0] <= {rd_enb_0, rd_adr_0, rd_exp};
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
            if (start_acc) begin
                fail      <= 1'b0;
                fail_adr  <= '0;
                fail_port <= 1'b0;
                err_cnt   <= '0;
            end else if (mis0 || mis1) begin
                fail    <= 1'b1;
                err_cnt <= err_sum[8] ? 8'd255 : err_sum[7:0];
                if (!fail) begin
                    fail_adr  <= cmp.adr;
                    fail_port <= !mis0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ra_march_sdr.sv
// Bench for ra_march_sdr: behavioural array with read-path stuck-at faults and a march-level reference model.
module tb_ra_march_sdr;

    localparam int RD_LAT = 1;
    localparam int N_TRAFFIC = 384;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [0:71] bkgnd;
    logic        rd_enb_0, rd_enb_1, wr_enb_0;
    logic [0:5]  rd_adr_0, rd_adr_1, wr_adr_0;
    logic [0:71] rd_dat_0, rd_dat_1, wr_dat_0;
    logic        busy, done, fail, fail_port;
    logic [0:5]  fail_adr;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    ra_march_sdr #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .bkgnd(bkgnd),
        .rd_enb_0(rd_enb_0), .rd_enb_1(rd_enb_1),
        .rd_adr_0(rd_adr_0), .rd_adr_1(rd_adr_1),
        .rd_dat_0(rd_dat_0), .rd_dat_1(rd_dat_1),
        .wr_enb_0(wr_enb_0), .wr_adr_0(wr_adr_0), .wr_dat_0(wr_dat_0),
        .busy(busy), .done(done), .fail(fail), .fail_adr(fail_adr),
        .fail_port(fail_port), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Array model: fault-free cells, per-port/per-address stuck-at masks on the read path.
    logic [0:71] mem [64];
    logic [0:71] sa0 [2][64];
    logic [0:71] sa1 [2][64];
    logic [0:71] pipe0 [RD_LAT];
    logic [0:71] pipe1 [RD_LAT];

    function automatic logic [0:71] faulty(input int p, input int a, input logic [0:71] v);
        return (v & ~sa0[p][a]) | sa1[p][a];
    endfunction

    always @(posedge clk) begin
        if (wr_enb_0) mem[wr_adr_0] <= wr_dat_0;
        pipe0[0] <= faulty(0, int'(rd_adr_0), mem[rd_adr_0]);
        pipe1[0] <= faulty(1, int'(rd_adr_1), mem[rd_adr_1]);
        for (int i = 1; i < RD_LAT; i++) begin
            pipe0[i] <= pipe0[i-1];
            pipe1[i] <= pipe1[i-1];
        end
    end
    assign rd_dat_0 = pipe0[RD_LAT-1];
    assign rd_dat_1 = pipe1[RD_LAT-1];

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_faults();
        for (int p = 0; p < 2; p++)
            for (int a = 0; a < 64; a++) begin
                sa0[p][a] = '0;
                sa1[p][a] = '0;
            end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctl"}, {rd_enb_0, rd_enb_1, wr_enb_0, busy, done, fail, fail_port,
                             rd_adr_0, rd_adr_1, wr_adr_0, fail_adr, err_cnt}, '0);
        check({tag, "_wdat"}, wr_dat_0, '0);
    endtask

    // Reference: the march as a list of one operation per traffic cycle.
    typedef struct {
        bit          wr;
        logic [0:5]  adr;
        logic [0:71] dat;
    } op_t;
    op_t ops[$];

    function automatic logic [0:71] pat(input logic [0:71] d, input int a, input bit inv);
        logic [0:71] r;
        r = inv ? ~d : d;
`ifdef RA_MARCH_CHKBD_EN
        if (a % 2 == 1) r = ~r;
`endif
        return r;
    endfunction

    task automatic build_ops(input logic [0:71] d);
        ops.delete();
        for (int a = 0; a < 64; a++) ops.push_back('{1'b1, 6'(a), pat(d, a, 1'b0)});
        for (int a = 0; a < 64; a++) begin
            ops.push_back('{1'b0, 6'(a), pat(d, a, 1'b0)});
            ops.push_back('{1'b1, 6'(a), pat(d, a, 1'b1)});
        end
        for (int a = 63; a >= 0; a--) begin
            ops.push_back('{1'b0, 6'(a), pat(d, a, 1'b1)});
            ops.push_back('{1'b1, 6'(a), pat(d, a, 1'b0)});
        end
        for (int a = 63; a >= 0; a--) ops.push_back('{1'b0, 6'(a), pat(d, a, 1'b0)});
    endtask

    int m_err, m_adr, m_port, m_fcyc;
    bit m_fail;

    task automatic model_scores();
        m_err = 0; m_fail = 0; m_adr = 0; m_port = 0; m_fcyc = -1;
        for (int i = 0; i < ops.size(); i++) begin
            if (!ops[i].wr) begin
                for (int p = 0; p < 2; p++) begin
                    if (faulty(p, int'(ops[i].adr), ops[i].dat) != ops[i].dat) begin
                        if (m_err < 255) m_err++;
                        if (!m_fail) begin
                            m_fail = 1;
                            m_adr  = int'(ops[i].adr);
                            m_port = p;
                            m_fcyc = i + 1 + RD_LAT + 1;
                        end
                    end
                end
            end
        end
    endtask

    logic [0:71] w_dat1, w_dat2;

    task automatic run_march(input string tag, input logic [0:71] d, input int restart_at, input int abort_at);
        int cyc, done_cyc, fail_cyc, bad, nwr, nrd;
        op_t op;
        build_ops(d);
        model_scores();
        done_cyc = -1; fail_cyc = -1; bad = 0; nwr = 0; nrd = 0;
        @(negedge clk);
        bkgnd = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_rise"}, {busy, wr_enb_0}, 2'b11);
        cyc = 1;
        while (cyc < 1000) begin
            if (cyc == abort_at) begin
                reset = 1'b0;
                #1;
                check_reset_vals({tag, "_rst_async"});
                repeat (3) @(negedge clk);
                check_reset_vals({tag, "_rst_hold"});
                reset = 1'b1;
                return;
            end
            if (cyc <= N_TRAFFIC) begin
                op = ops[cyc-1];
                if (wr_enb_0 !== op.wr || rd_enb_0 !== !op.wr || rd_enb_1 !== !op.wr) bad++;
                else if (op.wr && (wr_adr_0 !== op.adr || wr_dat_0 !== op.dat)) bad++;
                else if (!op.wr && (rd_adr_0 !== op.adr || rd_adr_1 !== op.adr)) bad++;
            end else if (wr_enb_0 || rd_enb_0 || rd_enb_1) begin
                bad++;
            end
            if (cyc == 1) w_dat1 = wr_dat_0;
            if (cyc == 2) w_dat2 = wr_dat_0;
            if (wr_enb_0) nwr++;
            if (rd_enb_0) nrd++;
            if (fail && fail_cyc < 0) fail_cyc = cyc;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (!busy) bad++;
            start = (cyc == restart_at);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_done_cyc"}, done_cyc, 385 + RD_LAT);
        check({tag, "_busy_fall"}, busy, 1'b0);
        check({tag, "_traffic"}, bad, 0);
        check({tag, "_nwr"}, nwr, 192);
        check({tag, "_nrd"}, nrd, 192);
        check({tag, "_idle_out"}, {rd_adr_0, rd_adr_1, wr_adr_0, wr_dat_0}, '0);
        check({tag, "_fail"}, fail, m_fail);
        check({tag, "_fail_adr"}, fail_adr, m_adr);
        check({tag, "_fail_port"}, fail_port, m_port);
        check({tag, "_err_cnt"}, err_cnt, m_err);
        check({tag, "_fail_cyc"}, fail_cyc, m_fcyc);
        @(negedge clk);
        check({tag, "_done_hold"}, {done, busy}, 2'b10);
    endtask

    initial begin
        logic [0:71] d;
        reset = 1'b0;
        start = 1'b0;
        bkgnd = '0;
        clear_faults();
        repeat (3) @(negedge clk);
        check_reset_vals("init");
        reset = 1'b1;

        run_march("clean_a5", {9{8'hA5}}, 0, 0);

        run_march("clean_zero", '0, 0, 0);
        check("w0_adr0", w_dat1, '0);
`ifdef RA_MARCH_CHKBD_EN
        check("w0_adr1", w_dat2, {72{1'b1}});
`else
        check("w0_adr1", w_dat2, '0);
`endif

        sa1[1][42][40] = 1'b1;
        run_march("stuck", '0, 0, 0);
        check("stuck_err2", err_cnt, 8'd2);
        check("stuck_where", {fail, fail_adr, fail_port}, {1'b1, 6'h2A, 1'b1});

        clear_faults();
        for (int p = 0; p < 2; p++)
            for (int a = 0; a < 64; a++) begin
                sa1[p][a][0] = 1'b1;
                sa0[p][a][1] = 1'b1;
            end
        run_march("sat", '0, 0, 0);
        check("sat_err", err_cnt, 8'd255);

        clear_faults();
        d = {$urandom(), $urandom(), 8'($urandom())};
        run_march("restart", d, 50, 0);
        run_march("abort", d, 0, 200);
        d = {$urandom(), $urandom(), 8'($urandom())};
        run_march("post_abort", d, 0, 0);

        for (int r = 0; r < 5; r++) begin
            clear_faults();
            for (int k = $urandom_range(0, 3); k > 0; k--) begin
                int p, a, b;
                p = $urandom_range(0, 1);
                a = $urandom_range(0, 63);
                b = $urandom_range(0, 71);
                if ($urandom_range(0, 1) == 1) sa1[p][a][b] = 1'b1;
                else sa0[p][a][b] = 1'b1;
            end
            d = {$urandom(), $urandom(), 8'($urandom())};
            run_march($sformatf("rand%0d", r), d, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
